// File: rtl/hms_clk_ctrl_if.sv
// Signal bundle between the HMS clock controller and its surroundings:
// buttons and counter max-hit flags in, counter clock pulses and mode out.
interface hms_clk_ctrl_if;
   logic       i_mode;
   logic       i_inc;
   logic       i_max_hit_sec;
   logic       i_max_hit_min;
   logic       o_sec_clk;
   logic       o_min_clk;
   logic       o_hour_clk;
   logic [1:0] o_mode;
   logic       o_tick;

   modport master (
      output i_mode, i_inc, i_max_hit_sec, i_max_hit_min,
      input  o_sec_clk, o_min_clk, o_hour_clk, o_mode, o_tick
   );

   modport slave (
      input  i_mode, i_inc, i_max_hit_sec, i_max_hit_min,
      output o_sec_clk, o_min_clk, o_hour_clk, o_mode, o_tick
   );
endinterface

// File: rtl/hms_clk_ctrl.sv
// Drive-side controller for the hour/minute/second counter chain: 1 Hz
// prescaler, carry pulses from counter max-hit edges, and a set-time mode FSM.
//
// state       | meaning
// ST_CLOCK    | free running; prescaler ticks and carries drive the pulses
// ST_SET_SEC  | inc button steps the seconds counter
// ST_SET_MIN  | inc button steps the minutes counter
// ST_SET_HOUR | inc button steps the hours counter
module hms_clk_ctrl #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic          clk,
   input  logic          rst,
   hms_clk_ctrl_if.slave bus
);

   localparam int             CW        = $clog2(CLK_HZ);
   localparam logic [CW-1:0]  PRESC_TC  = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0]  PRESC_ONE = CW'(1);

   typedef enum logic [1:0] {
      ST_CLOCK    = 2'd0,
      ST_SET_SEC  = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_HOUR = 2'd3
   } state_t;

   // bit 0 mode, bit 1 inc, bit 2 sec max-hit, bit 3 min max-hit
   logic [3:0]    in_raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    prev;
   logic [3:0]    rise;
   logic          rise_mode;
   logic          inc_step;
   logic          presc_tc_hit;
   logic [CW-1:0] presc;
   state_t        state;
   logic          sec_clk;
   logic          min_clk;
   logic          hour_clk;

   assign in_raw = {bus.i_max_hit_min, bus.i_max_hit_sec, bus.i_inc, bus.i_mode};
   assign rise   = sync2 & ~prev;

   assign rise_mode    = rise[0];
   // A mode press in the same cycle as an inc press swallows the inc.
   assign inc_step     = rise[1] & ~rise[0];
   assign presc_tc_hit = (presc == PRESC_TC);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         presc    <= '0;
         state    <= ST_CLOCK;
         sec_clk  <= 1'b0;
         min_clk  <= 1'b0;
         hour_clk <= 1'b0;
      end else begin
         sync1    <= in_raw;
         sync2    <= sync1;
         prev     <= sync2;
         sec_clk  <= 1'b0;
         min_clk  <= 1'b0;
         hour_clk <= 1'b0;

         // Prescaler follows the current state, so it is still 0 on the
         // edge that returns to CLOCK and a full second elapses first.
         case (state)
            ST_CLOCK: begin
               presc    <= presc_tc_hit ? '0 : presc + PRESC_ONE;
               sec_clk  <= presc_tc_hit;
               min_clk  <= rise[2];
               hour_clk <= rise[3];
            end
            ST_SET_SEC: begin
               presc   <= '0;
               sec_clk <= inc_step;
            end
            ST_SET_MIN: begin
               presc   <= '0;
               min_clk <= inc_step;
            end
            ST_SET_HOUR: begin
               presc    <= '0;
               hour_clk <= inc_step;
            end
            default: begin
               presc <= '0;
            end
         endcase

         if (rise_mode) begin
            case (state)
               ST_CLOCK:    state <= ST_SET_SEC;
               ST_SET_SEC:  state <= ST_SET_MIN;
               ST_SET_MIN:  state <= ST_SET_HOUR;
               ST_SET_HOUR: state <= ST_CLOCK;
               default:     state <= ST_CLOCK;
            endcase
         end
      end
   end

   assign bus.o_sec_clk  = sec_clk;
   assign bus.o_min_clk  = min_clk;
   assign bus.o_hour_clk = hour_clk;
   assign bus.o_mode     = state;
   assign bus.o_tick     = (state == ST_CLOCK) && presc_tc_hit;

endmodule
